// File: rtl/if_pkg.sv
// if_pkg: shared constants and the fetch-queue entry type for the prefetch unit
package if_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruct;
  } fetch_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: sync FIFO of fetch entries; flush/push/pop in, head/count/empty/full out, empty head reads NOP@RESET_PC
module ifq_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign wr = push && (!full || pop) && !flush;
  assign rd = pop && !empty && !flush;
  assign head = empty ? fetch_entry_t'({RESET_PC, NOP}) : mem[rp];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wr ? wp + AW'(1) : wp;
      rp <= rd ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge i_clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction prefetcher; imem req/gnt/rvalid side, decode valid/ready side, redirect flushes and discards stale responses
module prefetch_unit
  import if_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instruct,
  output logic [31:0] o_pc_cur,
  output logic [31:0] o_pc_four
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fetch_pc, resp_pc, tgt;
  logic [CW-1:0] inflight, discard, count;
  logic empty, full, fire, rv, push, pop;
  fetch_entry_t head;
  assign tgt = i_redirect_pc & ~32'h3;
  // a response with nothing outstanding belongs to a request abandoned by reset
  assign rv = i_imem_rvalid && inflight != '0;
  assign push = rv && discard == '0 && !i_redirect;
  assign o_imem_req = !i_rst && !i_redirect && !full && ({1'b0, inflight} + {1'b0, count} < (CW+1)'(DEPTH));
  assign o_imem_addr = fetch_pc;
  assign fire = o_imem_req && i_imem_gnt;
  assign o_valid = !empty && !i_redirect;
  assign pop = o_valid && i_ready;
  assign o_instruct = head.instruct;
  assign o_pc_cur = head.pc;
  assign o_pc_four = head.pc + 32'd4;
  ifq_fifo #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_ifq (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .flush(i_redirect),
    .push(push),
    .pop(pop),
    .din(fetch_entry_t'({resp_pc, i_imem_rdata})),
    .head(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      inflight <= '0;
      discard <= '0;
    end else begin
      inflight <= inflight + CW'(fire) - CW'(rv);
      fetch_pc <= i_redirect ? tgt : fire ? fetch_pc + 32'd4 : fetch_pc;
      resp_pc <= i_redirect ? tgt : push ? resp_pc + 32'd4 : resp_pc;
      // every request still outstanding after this edge is stale; discard is a subset of inflight
      discard <= i_redirect ? inflight - CW'(rv) : (rv && discard != '0) ? discard - CW'(1) : discard;
    end
endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: directed self-checking bench for prefetch_unit with a latency-programmable memory model
module tb_prefetch_unit;
  import if_pkg::*;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
  logic i_clk = 0, i_rst = 1, i_redirect = 0, i_imem_gnt = 1, i_imem_rvalid = 0, i_ready = 1;
  logic [31:0] i_redirect_pc = 0, i_imem_rdata = 0;
  logic o_imem_req, o_valid;
  logic [31:0] o_imem_addr, o_instruct, o_pc_cur, o_pc_four;
  int vec = 0, miss = 0, lat = 1, cyc = 0, grants = 0;
  logic stray = 0, m_hs, m_take;
  logic [31:0] m_addr, q_addr[$];
  int q_due[$];

  always #5 i_clk = ~i_clk;

  prefetch_unit #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata), .o_valid(o_valid),
    .i_ready(i_ready), .o_instruct(o_instruct), .o_pc_cur(o_pc_cur), .o_pc_four(o_pc_four)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_F00F;
  endfunction

  always begin
    @(negedge i_clk);
    #4;
    m_hs = o_imem_req && i_imem_gnt;
    m_addr = o_imem_addr;
    m_take = i_imem_rvalid && q_addr.size() > 0;
    @(posedge i_clk);
    #1;
    cyc++;
    if (i_rst) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (m_take) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (m_hs) begin
        q_addr.push_back(m_addr);
        q_due.push_back(cyc + lat - 1);
        grants++;
      end
    end
    i_imem_rvalid = stray || (q_due.size() > 0 && q_due[0] <= cyc);
    i_imem_rdata = stray ? 32'hDEAD_BEEF : q_addr.size() > 0 ? memf(q_addr[0]) : 32'h0;
  end

  task test_reset;
    repeat (2) @(negedge i_clk);
    vec++; if (o_imem_req !== 1'b0) begin miss++; $display("FAIL rst_req got %b exp 0", o_imem_req); end
    vec++; if (o_valid !== 1'b0) begin miss++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    vec++; if (o_imem_addr !== RPC) begin miss++; $display("FAIL rst_addr got %h exp %h", o_imem_addr, RPC); end
    vec++; if (o_instruct !== NOP) begin miss++; $display("FAIL rst_instr got %h exp %h", o_instruct, NOP); end
    vec++; if (o_pc_cur !== RPC) begin miss++; $display("FAIL rst_pc got %h exp %h", o_pc_cur, RPC); end
    vec++; if (o_pc_four !== 32'hFFFF_FFFC) begin miss++; $display("FAIL rst_pc4 got %h exp fffffffc", o_pc_four); end
    i_rst = 0;
    #1;
    vec++; if (o_imem_req !== 1'b1) begin miss++; $display("FAIL first_req got %b exp 1", o_imem_req); end
    vec++; if (o_imem_addr !== RPC) begin miss++; $display("FAIL first_addr got %h exp %h", o_imem_addr, RPC); end
  endtask

  task test_stream;
    logic [31:0] exp;
    int n;
    bit seen;
    exp = RPC; n = 0; seen = 0;
    for (int i = 0; i < 30 && n < 8; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        vec++;
        if ({o_pc_cur, o_instruct, o_pc_four} !== {exp, memf(exp), exp + 32'd4}) begin
          miss++; $display("FAIL stream got pc=%h ins=%h pc4=%h exp pc=%h", o_pc_cur, o_instruct, o_pc_four, exp);
        end
        n++; exp = exp + 32'd4; seen = 1;
      end else if (seen) begin
        vec++; miss++; $display("FAIL stream_bubble got valid=0 exp 1 at pc %h", exp);
      end
    end
    if (n < 8) begin vec++; miss++; $display("FAIL stream_timeout got %0d exp 8", n); end
  endtask

  task test_stall;
    int g0;
    logic [31:0] exp;
    @(negedge i_clk);
    i_redirect = 1; i_redirect_pc = 32'h0; i_ready = 0;
    #1;
    vec++; if ({o_valid, o_imem_req} !== 2'b00) begin miss++; $display("FAIL redir_gate got %b exp 00", {o_valid, o_imem_req}); end
    @(negedge i_clk);
    i_redirect = 0;
    g0 = grants;
    repeat (10) @(negedge i_clk);
    vec++; if (o_imem_req !== 1'b0) begin miss++; $display("FAIL stall_req got %b exp 0", o_imem_req); end
    vec++; if (grants - g0 !== 4) begin miss++; $display("FAIL stall_grants got %0d exp 4", grants - g0); end
    vec++; if ({o_valid, o_pc_cur, o_instruct} !== {1'b1, 32'h0, memf(32'h0)}) begin
      miss++; $display("FAIL stall_head got v=%b pc=%h ins=%h exp pc=0", o_valid, o_pc_cur, o_instruct);
    end
    i_ready = 1;
    exp = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      vec++;
      if ({o_valid, o_pc_cur, o_instruct} !== {1'b1, exp, memf(exp)}) begin
        miss++; $display("FAIL drain got v=%b pc=%h exp pc=%h", o_valid, o_pc_cur, exp);
      end
      exp = exp + 32'd4;
      @(negedge i_clk);
    end
  endtask

  task test_redirect_drop;
    int n;
    @(negedge i_clk);
    lat = 4; i_redirect = 1; i_redirect_pc = 32'h1000;
    @(negedge i_clk);
    i_redirect = 0;
    repeat (3) @(negedge i_clk);
    i_redirect = 1; i_redirect_pc = 32'h100;
    @(negedge i_clk);
    i_redirect = 0;
    #1;
    vec++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h100}) begin
      miss++; $display("FAIL drop_req got %b/%h exp 1/00000100", o_imem_req, o_imem_addr);
    end
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        vec++;
        if ({o_pc_cur, o_instruct} !== {32'h100 + 32'(4 * n), memf(32'h100 + 32'(4 * n))}) begin
          miss++; $display("FAIL drop_head got pc=%h ins=%h exp pc=%h", o_pc_cur, o_instruct, 32'h100 + 32'(4 * n));
        end
        n++;
      end
    end
    if (n < 2) begin vec++; miss++; $display("FAIL drop_timeout got %0d exp 2", n); end
  endtask

  task test_align;
    bit done;
    @(negedge i_clk);
    lat = 1; i_redirect = 1; i_redirect_pc = 32'h203;
    @(negedge i_clk);
    i_redirect = 0;
    #1;
    vec++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h200}) begin
      miss++; $display("FAIL align_addr got %b/%h exp 1/00000200", o_imem_req, o_imem_addr);
    end
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        done = 1;
        vec++; if (o_pc_cur !== 32'h200) begin miss++; $display("FAIL align_pc got %h exp 00000200", o_pc_cur); end
        vec++; if (o_pc_four !== 32'h204) begin miss++; $display("FAIL align_pc4 got %h exp 00000204", o_pc_four); end
        vec++; if (o_instruct !== memf(32'h200)) begin miss++; $display("FAIL align_ins got %h exp %h", o_instruct, memf(32'h200)); end
      end
    end
    if (!done) begin vec++; miss++; $display("FAIL align_timeout got none exp valid"); end
  endtask

  task test_double_redirect;
    int n;
    @(negedge i_clk);
    lat = 3; i_redirect = 1; i_redirect_pc = 32'h40;
    @(negedge i_clk);
    i_redirect = 0;
    @(negedge i_clk);
    i_redirect = 1; i_redirect_pc = 32'h80;
    @(negedge i_clk);
    i_redirect = 0;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        vec++;
        if ({o_pc_cur, o_instruct} !== {32'h80 + 32'(4 * n), memf(32'h80 + 32'(4 * n))}) begin
          miss++; $display("FAIL dbl_redir got pc=%h ins=%h exp pc=%h", o_pc_cur, o_instruct, 32'h80 + 32'(4 * n));
        end
        n++;
      end
    end
    if (n < 4) begin vec++; miss++; $display("FAIL dbl_timeout got %0d exp 4", n); end
  endtask

  task test_full_redirect;
    int n;
    @(negedge i_clk);
    lat = 1; i_ready = 0;
    repeat (10) @(negedge i_clk);
    vec++; if ({o_imem_req, o_valid} !== 2'b01) begin miss++; $display("FAIL full_state got %b exp 01", {o_imem_req, o_valid}); end
    i_redirect = 1; i_redirect_pc = 32'h300;
    #1;
    vec++; if (o_valid !== 1'b0) begin miss++; $display("FAIL full_flush_valid got %b exp 0", o_valid); end
    @(negedge i_clk);
    i_redirect = 0; i_ready = 1;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        vec++;
        if (o_pc_cur !== 32'h300 + 32'(4 * n)) begin
          miss++; $display("FAIL full_redir got pc=%h exp %h", o_pc_cur, 32'h300 + 32'(4 * n));
        end
        n++;
      end
    end
    if (n < 2) begin vec++; miss++; $display("FAIL full_timeout got %0d exp 2", n); end
  endtask

  task test_reset_mid;
    int n;
    repeat (5) @(negedge i_clk);
    #2;
    i_rst = 1;
    #1;
    vec++; if ({o_valid, o_imem_req} !== 2'b00) begin miss++; $display("FAIL midrst_out got %b exp 00", {o_valid, o_imem_req}); end
    vec++; if ({o_pc_cur, o_instruct} !== {RPC, NOP}) begin miss++; $display("FAIL midrst_head got %h/%h exp %h/%h", o_pc_cur, o_instruct, RPC, NOP); end
    i_imem_gnt = 0;
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    stray = 1;
    @(negedge i_clk);
    stray = 0;
    @(negedge i_clk);
    vec++; if (o_valid !== 1'b0) begin miss++; $display("FAIL stray_1 got %b exp 0", o_valid); end
    @(negedge i_clk);
    vec++; if (o_valid !== 1'b0) begin miss++; $display("FAIL stray_2 got %b exp 0", o_valid); end
    i_imem_gnt = 1;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        vec++;
        if ({o_pc_cur, o_instruct} !== {RPC + 32'(4 * n), memf(RPC + 32'(4 * n))}) begin
          miss++; $display("FAIL restart got pc=%h ins=%h exp pc=%h", o_pc_cur, o_instruct, RPC + 32'(4 * n));
        end
        n++;
      end
    end
    if (n < 2) begin vec++; miss++; $display("FAIL restart_timeout got %0d exp 2", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect_drop;
    test_align;
    test_double_redirect;
    test_full_redirect;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
